ternary_weight_store: RTL and testbench

TERNARY_WEIGHT_STORE -- requirements
Module: ternary_weight_store

---
 rtl/tt_ternary_pkg.sv | 23 ++
 rtl/ternary_row_assembler.sv | 74 +++++++
 rtl/ternary_weight_store.sv | 181 ++++++++++++++++++
 tb/tb_ternary_weight_store.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_ternary_pkg.sv
// Shared types and constants for the ternary weight store.
package tt_ternary_pkg;

    // Controller states: idle, accepting weight beats, streaming rows
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    // Two-bit ternary weight codes; weights are kept exactly as loaded
    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;
    localparam logic [1:0] W_RSVD = 2'b10;

    // Default geometry: 7 rows of 14 two-bit weights, loaded over a 14-bit bus
    localparam int DEF_IN_LEN  = 14;
    localparam int DEF_OUT_LEN = 7;
    localparam int DEF_WIDTH   = 2;
    localparam int DEF_BUS_W   = 14;

endpackage

// File: rtl/ternary_row_assembler.sv
// Collects BUS_W-wide chunks into one full row and flags reserved weight codes.
module ternary_row_assembler
    import tt_ternary_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BUS_W      = DEF_BUS_W,
    parameter int ROW_W      = DEF_WIDTH * DEF_IN_LEN,
    parameter int CHUNKS     = ROW_W / BUS_W,
    parameter int CHUNK_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             accept_i,
    input  logic [BUS_W-1:0] data_i,
    output logic [ROW_W-1:0] row_data_o,
    output logic             row_commit_o,
    output logic             rsvd_o
);

    logic [CHUNK_BITS-1:0] chunk_q, chunk_d;
    logic [ROW_W-1:0]      asm_q, asm_d;
    logic                  last_chunk_s;

    assign last_chunk_s = (chunk_q == CHUNK_BITS'(CHUNKS - 1));
    assign row_commit_o = accept_i & last_chunk_s;

    // Row view with the current beat already merged, so the final chunk commits in the same cycle
    always_comb begin
        row_data_o = asm_q;
        for (int k = 0; k < CHUNKS; k++) begin
            if (int'(chunk_q) == k) begin
                row_data_o[k*BUS_W +: BUS_W] = data_i;
            end else begin
                row_data_o[k*BUS_W +: BUS_W] = asm_q[k*BUS_W +: BUS_W];
            end
        end
    end

    // Reserved-code scan over every weight field of an accepted beat
    always_comb begin
        rsvd_o = 1'b0;
        for (int f = 0; f < BUS_W / WIDTH; f++) begin
            rsvd_o = rsvd_o | (data_i[f*WIDTH +: WIDTH] == W_RSVD);
        end
        rsvd_o = rsvd_o & accept_i;
    end

    // Chunk counter and assembly register next state; a restart zeroes the counter
    always_comb begin
        chunk_d = chunk_q;
        asm_d   = asm_q;
        if (clear_i) begin
            chunk_d = '0;
        end else if (accept_i) begin
            asm_d   = row_data_o;
            chunk_d = last_chunk_s ? '0 : chunk_q + CHUNK_BITS'(1);
        end else begin
            chunk_d = chunk_q;
        end
    end

    // Assembler state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chunk_q <= '0;
            asm_q   <= '0;
        end else begin
            chunk_q <= chunk_d;
            asm_q   <= asm_d;
        end
    end

endmodule

// File: rtl/ternary_weight_store.sv
// Ternary weight store: chunked weight load into row storage, then cyclic row streaming.
module ternary_weight_store
    import tt_ternary_pkg::*;
#(
    parameter int  IN_LEN     = DEF_IN_LEN,
    parameter int  OUT_LEN    = DEF_OUT_LEN,
    parameter int  WIDTH      = DEF_WIDTH,
    parameter int  BUS_W      = DEF_BUS_W,
    localparam int ROW_W      = WIDTH * IN_LEN,
    localparam int CHUNKS     = ROW_W / BUS_W,
    localparam int OUT_BITS   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1,
    localparam int CHUNK_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_start_i,
    input  logic                in_valid_i,
    input  logic [BUS_W-1:0]    in_data_i,
    output logic                in_ready_o,
    input  logic                run_en_i,
    output logic [ROW_W-1:0]    row_out_o,
    output logic [OUT_BITS-1:0] row_idx_o,
    output logic                row_valid_o,
    output logic                load_done_o,
    output logic                loaded_o,
    output logic                err_code_o
);

    if ((ROW_W % BUS_W) != 0 || WIDTH != 2) begin : g_bad_cfg
        $error("ternary_weight_store: ROW_W must be a multiple of BUS_W and WIDTH must be 2");
    end

    state_e                state_q, state_d;
    logic [OUT_BITS-1:0]   row_cnt_q, row_cnt_d;
    logic [OUT_BITS-1:0]   ptr_q, ptr_d;
    logic [ROW_W-1:0]      row_out_q, row_out_d;
    logic [OUT_BITS-1:0]   row_idx_q, row_idx_d;
    logic                  row_valid_q, row_valid_d;
    logic                  load_done_q, load_done_d;
    logic                  loaded_q, loaded_d;
    logic                  err_q, err_d;
    logic [ROW_W-1:0]      mem [OUT_LEN];

    logic                  in_ready_s, accept_s, stream_s;
    logic                  commit_s, rsvd_s, last_row_s, load_cmplt_s;
    logic [ROW_W-1:0]      row_data_s;

    ternary_row_assembler #(
        .WIDTH      (WIDTH),
        .BUS_W      (BUS_W),
        .ROW_W      (ROW_W),
        .CHUNKS     (CHUNKS),
        .CHUNK_BITS (CHUNK_BITS)
    ) u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (load_start_i),
        .accept_i     (accept_s),
        .data_i       (in_data_i),
        .row_data_o   (row_data_s),
        .row_commit_o (commit_s),
        .rsvd_o       (rsvd_s)
    );

    assign last_row_s   = (row_cnt_q == OUT_BITS'(OUT_LEN - 1));
    assign load_cmplt_s = commit_s & last_row_s;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; load_start wins over everything else
    always_comb begin
        state_d = state_q;
        if (load_start_i) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: if (run_en_i && loaded_q) state_d = ST_RUN;  else state_d = ST_IDLE;
                ST_LOAD: if (load_cmplt_s)         state_d = ST_IDLE; else state_d = ST_LOAD;
                ST_RUN:  if (!run_en_i)            state_d = ST_IDLE; else state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output decode; streaming happens whenever the next state is RUN so the first row lands one cycle after run_en
    always_comb begin
        in_ready_s = (state_q == ST_LOAD);
        accept_s   = in_valid_i & in_ready_s & ~load_start_i;
        stream_s   = (state_d == ST_RUN);
    end

    // Datapath next state: row counter, read pointer, streamed row and status flags
    always_comb begin
        row_cnt_d   = row_cnt_q;
        ptr_d       = ptr_q;
        row_out_d   = row_out_q;
        row_idx_d   = row_idx_q;
        row_valid_d = 1'b0;
        load_done_d = 1'b0;
        loaded_d    = loaded_q;
        err_d       = err_q;
        if (load_start_i) begin
            row_cnt_d = '0;
            ptr_d     = '0;
            loaded_d  = 1'b0;
            err_d     = 1'b0;
        end else begin
            if (commit_s) begin
                row_cnt_d = last_row_s ? '0 : row_cnt_q + OUT_BITS'(1);
            end else begin
                row_cnt_d = row_cnt_q;
            end
            if (load_cmplt_s) begin
                load_done_d = 1'b1;
                loaded_d    = 1'b1;
                ptr_d       = '0;
            end else begin
                load_done_d = 1'b0;
            end
            if (rsvd_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if (stream_s) begin
                row_out_d   = mem[ptr_q];
                row_idx_d   = ptr_q;
                row_valid_d = 1'b1;
                ptr_d       = (ptr_q == OUT_BITS'(OUT_LEN - 1)) ? '0 : ptr_q + OUT_BITS'(1);
            end else begin
                row_valid_d = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_cnt_q   <= '0;
            ptr_q       <= '0;
            row_out_q   <= '0;
            row_idx_q   <= '0;
            row_valid_q <= 1'b0;
            load_done_q <= 1'b0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            row_cnt_q   <= row_cnt_d;
            ptr_q       <= ptr_d;
            row_out_q   <= row_out_d;
            row_idx_q   <= row_idx_d;
            row_valid_q <= row_valid_d;
            load_done_q <= load_done_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
        end
    end

    // Weight storage: written only on a row commit, never cleared; a reset cycle blocks the write
    always_ff @(posedge clk_i) begin
        if (commit_s && !rst_i) begin
            mem[row_cnt_q] <= row_data_s;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign row_out_o   = row_out_q;
    assign row_idx_o   = row_idx_q;
    assign row_valid_o = row_valid_q;
    assign load_done_o = load_done_q;
    assign loaded_o    = loaded_q;
    assign err_code_o  = err_q;

endmodule

// File: tb/tb_ternary_weight_store.sv
// Self-checking bench for ternary_weight_store with a row scoreboard.
module tb_ternary_weight_store;

    localparam int OUT_LEN = 7;
    localparam int BUS_W   = 14;
    localparam int ROW_W   = 28;
    localparam int NBEATS  = 14;

    typedef struct packed {
        logic [2:0]       idx;
        logic [ROW_W-1:0] data;
    } row_t;

    logic             clk = 1'b0;
    logic             rst, load_start, in_valid, run_en;
    logic [BUS_W-1:0] in_data;
    logic             in_ready, row_valid, load_done, loaded, err_code;
    logic [ROW_W-1:0] row_out;
    logic [2:0]       row_idx;

    row_t             sb[$];
    logic [BUS_W-1:0] beats [NBEATS];
    logic [ROW_W-1:0] model_mem [OUT_LEN];
    int               ptr_m;
    bit               err_m;
    bit               const_chk;
    int               chk_cnt  = 0;
    int               pass_cnt = 0;

    always #5 clk = ~clk;

    ternary_weight_store dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_start_i (load_start),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .run_en_i     (run_en),
        .row_out_o    (row_out),
        .row_idx_o    (row_idx),
        .row_valid_o  (row_valid),
        .load_done_o  (load_done),
        .loaded_o     (loaded),
        .err_code_o   (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Replace reserved fields so a beat carries only legal weights
    function automatic logic [BUS_W-1:0] clean(input logic [BUS_W-1:0] x);
        logic [BUS_W-1:0] y;
        y = x;
        for (int f = 0; f < BUS_W / 2; f++)
            if (y[f*2 +: 2] == 2'b10) y[f*2 +: 2] = 2'b01;
        return y;
    endfunction

    // Expected storage and error flag from the beats of one load
    task automatic build_model();
        err_m = 1'b0;
        for (int r = 0; r < OUT_LEN; r++)
            model_mem[r] = {beats[2*r+1], beats[2*r]};
        for (int b = 0; b < NBEATS; b++)
            for (int f = 0; f < BUS_W / 2; f++)
                if (beats[b][f*2 +: 2] == 2'b10) err_m = 1'b1;
        ptr_m = 0;
    endtask

    task automatic load_rows(input bit toggle, input bit hold_run, input bit skip_start);
        if (!skip_start) begin
            load_start = 1'b1; in_valid = 1'b0;
            @(negedge clk);
            load_start = 1'b0;
            chk("start_in_ready", in_ready, 1);
            chk("start_loaded", loaded, 0);
            chk("start_err_clr", err_code, 0);
        end
        for (int b = 0; b < NBEATS; b++) begin
            if (toggle) begin
                in_valid = 1'b0; in_data = 14'($urandom); run_en = hold_run;
                @(negedge clk);
            end
            in_valid = 1'b1; in_data = beats[b]; run_en = hold_run && (b < NBEATS - 1);
            @(negedge clk);
            if (b < NBEATS - 1) begin
                chk("mid_loaded", loaded, 0);
                chk("mid_done", load_done, 0);
                if (hold_run) chk("mid_run_ignored", row_valid, 0);
            end
        end
        in_valid = 1'b0; run_en = 1'b0;
        build_model();
        chk("done_pulse", load_done, 1);
        chk("done_loaded", loaded, 1);
        chk("done_in_ready", in_ready, 0);
        chk("done_err", err_code, 32'(err_m));
        @(negedge clk);
        chk("done_one_cycle", load_done, 0);
        chk("after_loaded", loaded, 1);
        chk("after_err", err_code, 32'(err_m));
    endtask

    task automatic run_rows(input int n, input bit keep);
        row_t e, g;
        logic [2:0] last_idx;
        last_idx = 3'd0;
        run_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            e.idx  = 3'(ptr_m);
            e.data = model_mem[ptr_m];
            sb.push_back(e);
            ptr_m = (ptr_m == OUT_LEN - 1) ? 0 : ptr_m + 1;
            @(negedge clk);
            chk("row_valid", row_valid, 1);
            g = sb.pop_front();
            chk("row_idx", row_idx, g.idx);
            chk("row_out", row_out, g.data);
            if (const_chk && g.idx == 3'd0) chk("row0_const", row_out, 32'h0008001);
            if (const_chk && g.idx == 3'd6) chk("row6_const", row_out, 32'h003800D);
            last_idx = g.idx;
        end
        if (!keep) begin
            run_en = 1'b0;
            @(negedge clk);
            chk("stop_valid", row_valid, 0);
            chk("stop_idx_hold", row_idx, last_idx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; run_en = 1'b0;
        in_data = 14'd0; const_chk = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_row_out", row_out, 0);
        chk("rst_row_idx", row_idx, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_err", err_code, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;

        // run_en before anything is loaded is ignored
        run_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("run_unloaded", row_valid, 0);
        end
        run_en = 1'b0;
        @(negedge clk);

        // Sequential beats 1..14; several of them hold 2'b10 fields, so the model expects err_code set
        for (int b = 0; b < NBEATS; b++) beats[b] = 14'(b + 1);
        load_rows(1'b0, 1'b0, 1'b0);
        const_chk = 1'b1;
        run_rows(9, 1'b0);
        run_rows(3, 1'b0);

        // Same contents loaded with in_valid toggling every cycle
        load_rows(1'b1, 1'b0, 1'b0);
        run_rows(7, 1'b0);
        const_chk = 1'b0;

        // Clean weights with a single reserved beat
        for (int b = 0; b < NBEATS; b++) beats[b] = clean(14'($urandom));
        beats[3] = 14'h0002;
        load_rows(1'b0, 1'b0, 1'b0);
        run_rows(2, 1'b0);

        // Restart mid-load: the beat presented with load_start is dropped
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; in_data = 14'h0002;
            @(negedge clk);
        end
        chk("pre_abort_err", err_code, 1);
        in_valid = 1'b1; in_data = 14'h0002; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0; in_valid = 1'b0;
        chk("abort_err_clr", err_code, 0);
        chk("abort_loaded", loaded, 0);
        chk("abort_in_ready", in_ready, 1);
        for (int b = 0; b < NBEATS; b++) beats[b] = clean(14'($urandom));
        load_rows(1'b0, 1'b1, 1'b1);
        run_rows(7, 1'b0);

        // Reset while streaming at row 3
        run_rows(4, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rrst_row_valid", row_valid, 0);
        chk("rrst_loaded", loaded, 0);
        chk("rrst_row_out", row_out, 0);
        chk("rrst_row_idx", row_idx, 0);
        chk("rrst_err", err_code, 0);
        chk("rrst_in_ready", in_ready, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rrst_run_ignored", row_valid, 0);
        end
        run_en = 1'b0;
        chk("sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
